// File: rtl/deinterleaver_fsm.sv
// -----------------------------------------------------------------------------
// deinterleaver_fsm
//
// Control sequencer for a ping-pong (two-bank) turbo-decoder deinterleaver.
// Soft bits arrive one per cycle and are written linearly into the current
// write bank. Meanwhile the opposite bank is read linearly. An external QPP
// generator maps rd_idx to the interleaved bank address. When the write bank
// is full and the read bank is drained, the banks swap roles without a bubble
// cycle. The final block of a stream (marked by in_last on its last bit) is
// drained on its own, then a one-cycle done pulse is issued.
//
// Ports
//   clk         : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   block_size  : K select, 0 -> 1056, 1 -> 6144 (sampled only with in_start)
//   in_start    : one-cycle pulse in IDLE that opens a stream
//   in_valid    : a soft bit is offered this cycle
//   in_last     : offered bit completes the final block of the stream
//   in_ready    : offered bit is accepted this cycle
//   ram_we[1:0] : one-hot write enable, bit0 = bank0, bit1 = bank1
//   wr_idx      : linear write index 0..K-1
//   rd_bank     : bank currently being read
//   rd_idx      : linear read index 0..K-1
//   out_valid   : read-side data valid
//   out_ready   : read-side consumer ready
//   out_last    : with out_valid on rd_idx = K-1
//   out_end     : with out_last on the final block of the stream
//   done        : one-cycle pulse once the stream is fully drained
//   state       : current FSM state (debug)
// -----------------------------------------------------------------------------
module deinterleaver_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        block_size,
  input  logic        in_start,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [1:0]  ram_we,
  output logic [12:0] wr_idx,
  output logic        rd_bank,
  output logic [12:0] rd_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_end,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned IDX_W = 13;
  localparam logic [IDX_W-1:0] K_SMALL_LAST = IDX_W'(1055);
  localparam logic [IDX_W-1:0] K_LARGE_LAST = IDX_W'(6143);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q,     state_d;
  logic             k_sel_q,     k_sel_d;
  logic             wbank_q,     wbank_d;
  logic             rd_bank_q,   rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q,    wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q,    rd_idx_d;
  logic             wr_full_q,   wr_full_d;
  logic             rd_empty_q,  rd_empty_d;
  logic             last_seen_q, last_seen_d;

  logic [IDX_W-1:0] k_last;
  logic             wr_acc;
  logic             wr_at_end;
  logic             rd_xfer;
  logic             rd_at_end;
  logic             wr_full_now;
  logic             rd_empty_now;
  logic             last_now;

  // Handshake and status decode
  assign k_last    = k_sel_q ? K_LARGE_LAST : K_SMALL_LAST;
  assign in_ready  = ((state_q == S_FILL) || (state_q == S_STREAM)) && !wr_full_q;
  assign wr_acc    = in_valid && in_ready;
  assign wr_at_end = (wr_idx_q == k_last);
  assign out_valid = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && !rd_empty_q;
  assign rd_xfer   = out_valid && out_ready;
  assign rd_at_end = (rd_idx_q == k_last);

  // "_now" views fold in this cycle's completing transfer, so a swap can be
  // taken on the very edge that finishes a bank instead of one cycle later.
  // This is what makes the first read appear one cycle after the last write
  // of block 1, and lets the two banks trade roles with no idle cycle.
  assign wr_full_now  = wr_full_q   || (wr_acc && wr_at_end);
  assign rd_empty_now = rd_empty_q  || (rd_xfer && rd_at_end);
  assign last_now     = last_seen_q || (wr_acc && wr_at_end && in_last);

  assign ram_we   = wr_acc ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
  assign wr_idx   = wr_idx_q;
  assign rd_idx   = rd_idx_q;
  assign rd_bank  = rd_bank_q;
  assign out_last = out_valid && rd_at_end;
  assign out_end  = out_last && (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;

  // Next-state and datapath-control update
  always_comb begin
    state_d     = state_q;
    k_sel_d     = k_sel_q;
    wbank_d     = wbank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wr_full_d   = wr_full_q;
    rd_empty_d  = rd_empty_q;
    last_seen_d = last_seen_q;

    // Write index advances on accept and parks at K-1 once the bank is full.
    // in_last only counts on the bit that completes a block.
    if (wr_acc) begin
      if (wr_at_end) begin
        wr_full_d = 1'b1;
        if (in_last) begin
          last_seen_d = 1'b1;
        end
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    // Read index advances on transfer and parks at K-1 once the bank is drained.
    if (rd_xfer) begin
      if (rd_at_end) begin
        rd_empty_d = 1'b1;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          k_sel_d     = block_size;
          wbank_d     = 1'b0;
          rd_bank_d   = 1'b0;
          wr_idx_d    = '0;
          rd_idx_d    = '0;
          wr_full_d   = 1'b0;
          rd_empty_d  = 1'b0;
          last_seen_d = 1'b0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        // Nothing is being read yet, so only the write side gates the swap.
        if (wr_full_now) begin
          rd_bank_d  = wbank_q;
          wbank_d    = ~wbank_q;
          wr_idx_d   = '0;
          rd_idx_d   = '0;
          wr_full_d  = 1'b0;
          rd_empty_d = 1'b0;
          state_d    = last_now ? S_DRAIN : S_STREAM;
        end
      end

      S_STREAM: begin
        if (wr_full_now && rd_empty_now) begin
          rd_bank_d  = wbank_q;
          wbank_d    = ~wbank_q;
          wr_idx_d   = '0;
          rd_idx_d   = '0;
          wr_full_d  = 1'b0;
          rd_empty_d = 1'b0;
          state_d    = last_now ? S_DRAIN : S_STREAM;
        end
      end

      S_DRAIN: begin
        if (rd_empty_now) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_sel_q     <= 1'b0;
      wbank_q     <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      wr_full_q   <= 1'b0;
      rd_empty_q  <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_sel_q     <= k_sel_d;
      wbank_q     <= wbank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wr_full_q   <= wr_full_d;
      rd_empty_q  <= rd_empty_d;
      last_seen_q <= last_seen_d;
    end
  end

endmodule

// File: tb/tb_deinterleaver_fsm.sv
// -----------------------------------------------------------------------------
// tb_deinterleaver_fsm
//
// Directed bench for deinterleaver_fsm. Each stream is driven cycle by cycle
// from one task; a small scoreboard tracks the expected write bank/index,
// the order in which banks must be read back, and where out_last/out_end
// belong. Results of each stream are then checked with immediate assertions.
// -----------------------------------------------------------------------------
module tb_deinterleaver_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        block_size = 1'b0;
  logic        in_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [1:0]  ram_we;
  logic [12:0] wr_idx;
  logic        rd_bank;
  logic [12:0] rd_idx;
  logic        out_valid;
  logic        out_last;
  logic        out_end;
  logic        done;
  logic [2:0]  state;

  deinterleaver_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .block_size (block_size),
    .in_start   (in_start),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .wr_idx     (wr_idx),
    .rd_bank    (rd_bank),
    .rd_idx     (rd_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_end    (out_end),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Results of the most recent stream
  int r_wr, r_rd, r_done, r_err, r_drop, r_lat1, r_lat2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one stream. stall_at/stall_len hold out_ready low for a window,
  // tog wiggles block_size every cycle, spur injects a stray in_start during
  // STREAM and an in_last on bit 10, abort_at pulls reset at that cycle.
  task automatic run_stream(input logic bs, input int nblk, input int stall_at,
                            input int stall_len, input bit tog, input bit spur,
                            input int abort_at);
    int K;
    int total;
    int bits, reads, ndone, err, drops;
    int exp_wb, exp_wi, exp_ri, rd_blk;
    int t_fill1, t_first_ov, t_end, t_done;
    int blkq[$];
    logic [2:0] st_prev;
    bit spur_done;
    K = bs ? 6144 : 1056;
    total = nblk * K;
    bits = 0; reads = 0; ndone = 0; err = 0; drops = 0;
    exp_wb = 0; exp_wi = 0; exp_ri = 0; rd_blk = 0;
    t_fill1 = -1; t_first_ov = -1; t_end = -1; t_done = -1;
    st_prev = 3'd0; spur_done = 1'b0;

    @(negedge clk);
    in_start = 1'b1; block_size = bs; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int t = 0; t < total + K + stall_len + 200; t++) begin
      if (t == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_mid_a", 32'({in_ready, ram_we, wr_idx, rd_bank, out_valid}), 32'd0);
        check("rst_mid_b", 32'({rd_idx, out_last, out_end, done}), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end
      in_valid   = (bits < total);
      in_last    = (bits == total - 1) || (spur && bits == 10);
      out_ready  = !(t >= stall_at && t < stall_at + stall_len);
      block_size = tog ? ((t % 2) == 1) : bs;
      in_start   = 1'b0;
      if (spur && !spur_done && st_prev == 3'd2) begin
        in_start  = 1'b1;
        spur_done = 1'b1;
      end
      #1;
      // write side
      if (in_valid && in_ready) begin
        if (ram_we !== ((exp_wb != 0) ? 2'b10 : 2'b01) || 32'(wr_idx) !== exp_wi) err++;
        bits++;
        if (exp_wi == K - 1) begin
          blkq.push_back(exp_wb);
          exp_wb = exp_wb ^ 1;
          exp_wi = 0;
          if (t_fill1 < 0) t_fill1 = t;
        end else begin
          exp_wi++;
        end
      end else begin
        if (ram_we !== 2'b00) err++;
        if (in_valid && state == 3'd2) begin
          drops++;
          if (32'(wr_idx) !== K - 1) err++;
        end
      end
      // read side
      if (out_valid && t_first_ov < 0) t_first_ov = t;
      if (out_valid && out_ready) begin
        if (blkq.size() == 0) err++;
        else if (rd_bank !== 1'(blkq[0])) err++;
        if (32'(rd_idx) !== exp_ri) err++;
        if (out_last !== (exp_ri == K - 1)) err++;
        if (out_end !== (exp_ri == K - 1 && rd_blk == nblk - 1)) err++;
        if (out_end) t_end = t;
        reads++;
        if (exp_ri == K - 1) begin
          exp_ri = 0;
          if (blkq.size() != 0) void'(blkq.pop_front());
          rd_blk++;
        end else begin
          exp_ri++;
        end
      end
      if (done) begin
        ndone++;
        t_done = t;
      end
      st_prev = state;
      if (t_done >= 0 && t > t_done + 2) break;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_start = 1'b0; out_ready = 1'b0;
    r_wr = bits; r_rd = reads; r_done = ndone; r_err = err; r_drop = drops;
    r_lat1 = t_first_ov - t_fill1;
    r_lat2 = t_done - t_end;
  endtask

  initial begin
    // Reset state
    in_valid = 1'b1; out_ready = 1'b1; in_start = 1'b0;
    #12;
    check("reset_out_a", 32'({in_ready, ram_we, wr_idx, rd_bank, out_valid}), 32'd0);
    check("reset_out_b", 32'({rd_idx, out_last, out_end, done}), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // IDLE without in_start stays put
    repeat (3) @(negedge clk);
    #1;
    check("idle_hold_state", 32'(state), 32'd0);
    check("idle_hold_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // K=1056 single block
    run_stream(1'b0, 1, 1 << 30, 0, 1'b0, 1'b0, -1);
    check("single_wr", r_wr, 1056);
    check("single_rd", r_rd, 1056);
    check("single_err", r_err, 0);
    check("single_done", r_done, 1);
    check("single_lat_first", r_lat1, 1);
    check("single_lat_done", r_lat2, 1);
    check("single_idle_after", 32'(state), 32'd0);

    // Three K=6144 blocks back to back
    run_stream(1'b1, 3, 1 << 30, 0, 1'b0, 1'b0, -1);
    check("b2b_wr", r_wr, 18432);
    check("b2b_rd", r_rd, 18432);
    check("b2b_err", r_err, 0);
    check("b2b_done", r_done, 1);
    check("b2b_no_drop", r_drop, 0);

    // Read stall of 200 cycles during block 2
    run_stream(1'b0, 3, 1156, 200, 1'b0, 1'b0, -1);
    check("stall_wr", r_wr, 3168);
    check("stall_rd", r_rd, 3168);
    check("stall_err", r_err, 0);
    check("stall_drop", r_drop, 200);
    check("stall_done", r_done, 1);

    // block_size toggled while streaming
    run_stream(1'b0, 2, 1 << 30, 0, 1'b1, 1'b0, -1);
    check("tog_rd", r_rd, 2112);
    check("tog_err", r_err, 0);
    check("tog_done", r_done, 1);

    // Stray in_start in STREAM and in_last on a non-final bit
    run_stream(1'b0, 2, 1 << 30, 0, 1'b0, 1'b1, -1);
    check("spur_wr", r_wr, 2112);
    check("spur_rd", r_rd, 2112);
    check("spur_err", r_err, 0);
    check("spur_done", r_done, 1);

    // Reset mid-STREAM, then a clean restart
    run_stream(1'b0, 3, 1 << 30, 0, 1'b0, 1'b0, 1500);
    check("abort_no_done", r_done, 0);
    check("abort_state", 32'(state), 32'd0);
    run_stream(1'b0, 1, 1 << 30, 0, 1'b0, 1'b0, -1);
    check("restart_rd", r_rd, 1056);
    check("restart_err", r_err, 0);
    check("restart_done", r_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, assertions %0d failures %0d", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
